uart_multibyte_rx: RTL and testbench

UART receiver that deserialises NUM_BYTES consecutive 8N1 frames from the serial line and assembles them into one parallel word. It sits directly downstream of the multibyte UART transmitter on the serial link. The transmitter sends the least-significant byte first, so this block places the first received byte in `data[7:0]`. It runs at 100 MHz and 9600 baud by default.

---
 rtl/uart_multibyte_rx.sv | 147 ++++++++++++++
 tb/tb_uart_multibyte_rx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_multibyte_rx.sv
// 8N1 UART receiver that assembles NUM_BYTES consecutive frames into one word, first byte in the LSBs.
// Optional macro UART_RX_TIMEOUT_EN discards a partial word after 20 idle bit-times.
module uart_multibyte_rx #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int NUM_BYTES    = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   RxD,
  output logic [8*NUM_BYTES-1:0] data,
  output logic                   valid,
  output logic                   frame_error,
  output logic                   busy
);

  // state   | meaning
  // S_IDLE  | line idle, waiting for a start-bit falling edge
  // S_START | confirming the start bit at its midpoint
  // S_DATA  | sampling 8 data bits at their midpoints, LSB first
  // S_STOP  | sampling the stop bit, committing the byte
  // S_BREAK | bad stop bit seen, waiting for the line to return high
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [BW-1:0] LAST = BW'(NUM_BYTES - 1);

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_TICKS = 20 * CLKS_PER_BIT;
  localparam int TW = $clog2(TO_TICKS);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_TICKS - 1);
  logic [TW-1:0] to_cnt;
`endif

  state_t                 state;
  logic                   rx_m, rx_s;
  logic [CW-1:0]          cnt;
  logic [2:0]             bit_idx;
  logic [BW-1:0]          byte_idx;
  logic [7:0]             shreg;
  logic [8*NUM_BYTES-1:0] asm_q, asm_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RxD;
      rx_s <= rx_m;
    end
  end

  // Assembly word with the byte just received dropped into its slot.
  always_comb begin
    asm_next = asm_q;
    asm_next[int'(byte_idx)*8 +: 8] = shreg;
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      shreg       <= '0;
      asm_q       <= '0;
      data        <= '0;
      valid       <= 1'b0;
      frame_error <= 1'b0;
`ifdef UART_RX_TIMEOUT_EN
      to_cnt      <= '0;
`endif
    end else begin
      valid       <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= S_START;
`ifdef UART_RX_TIMEOUT_EN
          if (!rx_s || byte_idx == '0) begin
            to_cnt <= '0;
          end else if (to_cnt == TO_LAST) begin
            to_cnt   <= '0;
            byte_idx <= '0;
            asm_q    <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        S_START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            if (bit_idx == 3'd7) state <= S_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == FULL) begin
            cnt <= '0;
            if (rx_s) begin
              state <= S_IDLE;
              if (byte_idx == LAST) begin
                data     <= asm_next;
                valid    <= 1'b1;
                asm_q    <= '0;
                byte_idx <= '0;
              end else begin
                asm_q    <= asm_next;
                byte_idx <= byte_idx + 1'b1;
              end
            end else begin
              frame_error <= 1'b1;
              byte_idx    <= '0;
              asm_q       <= '0;
              state       <= S_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BREAK: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_multibyte_rx.sv
// Scoreboard bench for uart_multibyte_rx: frame-level model feeds an expected-event queue, a monitor checks outputs.
module tb_uart_multibyte_rx;
  localparam int CPB = 16;
  localparam int NB  = 2;
  localparam int W   = 8 * NB;

  logic         clock;
  logic         reset;
  logic         RxD;
  logic [W-1:0] data;
  logic         valid;
  logic         frame_error;
  logic         busy;

  uart_multibyte_rx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB)) dut (
    .clock(clock), .reset(reset), .RxD(RxD),
    .data(data), .valid(valid), .frame_error(frame_error), .busy(busy)
  );

  typedef struct {
    bit           err;
    logic [W-1:0] word;
  } ev_t;

  ev_t          sb[$];
  logic [7:0]   partial[$];
  ev_t          mon_e;
  logic [W-1:0] hold;
  int           cyc = 0;
  int           last_valid_cyc = 0;
  int           t_start = 0;
  int           checks = 0;
  int           failures = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference model: works on whole frames and gaps, not on clock cycles.
  task automatic model_frame(input logic [7:0] b, input bit ok);
    logic [W-1:0] w;
    if (ok) begin
      partial.push_back(b);
      if (partial.size() == NB) begin
        w = '0;
        for (int i = 0; i < NB; i++) w[8*i +: 8] = partial[i];
        sb.push_back('{err: 1'b0, word: w});
        partial.delete();
      end
    end else begin
      sb.push_back('{err: 1'b1, word: '0});
      partial.delete();
    end
  endtask

  task automatic model_gap(input int bits);
`ifdef UART_RX_TIMEOUT_EN
    if (bits >= 20) partial.delete();
`endif
  endtask

  task automatic drive_bit(input logic v);
    RxD = v;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit ok);
    model_frame(b, ok);
    t_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(ok);
    RxD = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    model_gap(n);
    RxD = 1'b1;
    repeat (n * CPB) @(negedge clock);
  endtask

  always @(posedge clock) begin
    #2;
    if (reset) begin
      check(data == '0 && !valid && !frame_error && !busy, "reset_outputs",
            {data, valid, frame_error, busy}, 64'h0);
      hold = '0;
    end else if (valid || frame_error) begin
      check(!(valid && frame_error), "valid_ferr_exclusive", {valid, frame_error}, 2'b10);
      if (sb.size() == 0) begin
        check(1'b0, "unexpected_event", {valid, frame_error}, 2'b00);
      end else begin
        mon_e = sb.pop_front();
        check(frame_error == mon_e.err, "event_kind", frame_error, mon_e.err);
        if (valid) begin
          check(data == mon_e.word, "word", data, mon_e.word);
          check(busy == 1'b0, "busy_after_stop", busy, 1'b0);
          hold = mon_e.word;
          last_valid_cyc = cyc;
        end
      end
    end else begin
      check(data == hold, "data_hold", data, hold);
    end
  end

  initial begin
    int lat;
    int gap;
    logic [7:0] b;
    bit ok;
    RxD   = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    idle_bits(2);

    // Basic word and start-to-valid latency of the last frame.
    send_frame(8'h34, 1'b1);
    send_frame(8'h12, 1'b1);
    lat = last_valid_cyc - t_start;
    check(lat >= 153 && lat <= 155, "latency", lat, 154);
    idle_bits(2);
    check(busy == 1'b0, "busy_idle", busy, 1'b0);

    // Short glitch must abort at the mid-start check.
    RxD = 1'b0;
    repeat (3) @(negedge clock);
    check(busy == 1'b1, "busy_on_glitch", busy, 1'b1);
    RxD = 1'b1;
    repeat (20) @(negedge clock);
    check(busy == 1'b0, "busy_after_glitch", busy, 1'b0);
    idle_bits(1);

    // Bad stop bit discards the byte, then a clean word.
    send_frame(8'h55, 1'b0);
    idle_bits(1);
    send_frame(8'hCD, 1'b1);
    send_frame(8'hAB, 1'b1);
    idle_bits(2);

    // Reset during bit 4 of the second frame.
    send_frame(8'h77, 1'b1);
    b = 8'h96;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    RxD = b[4];
    repeat (5) @(negedge clock);
    reset = 1'b1;
    RxD   = 1'b1;
    partial.delete();
    @(negedge clock);
    reset = 1'b0;
    idle_bits(12);
    send_frame(8'h5A, 1'b1);
    send_frame(8'hA5, 1'b1);
    idle_bits(2);

    // Back-to-back frames with no idle gap.
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    send_frame(8'h03, 1'b1);
    send_frame(8'h04, 1'b1);
    idle_bits(2);

    // Long idle inside a word; outcome depends on the timeout build option.
    send_frame(8'h11, 1'b1);
    idle_bits(25);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    idle_bits(2);

    // Randomised frames, stop errors and short gaps.
    for (int n = 0; n < 40; n++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 7) != 0);
      send_frame(b, ok);
      gap = ok ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 3));
      if (gap > 0) idle_bits(gap);
    end
    idle_bits(2);

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clock);
    check(sb.size() == 0, "scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
